// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator for the decode stage.
// Each accepted instruction is decoded to {imm, fmt, pc + imm} and presented
// one cycle later. An output register plus one skid entry absorb downstream
// stalls, so in_ready is a flop output with no path from out_ready.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  // Only RV32 and RV64 datapaths are meaningful.
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit IS64 = (XLEN == 64);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_t;

  // One buffered transaction: everything downstream needs, already decoded.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec;

  entry_t          out_q;
  entry_t          skid_q;
  logic            skid_full;
  logic            in_fire;
  logic            out_open;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Classify the incoming instruction by opcode (and funct3 for SYSTEM).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    dec_fmt = FMT_ILL;
    if (in_inst[1:0] == 2'b11) begin
      case (opcode)
        7'b0000011, 7'b0010011,
        7'b0001111, 7'b1100111: dec_fmt = FMT_I;
        7'b0100011:             dec_fmt = FMT_S;
        7'b1100011:             dec_fmt = FMT_B;
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111:             dec_fmt = FMT_J;
        7'b0110011:             dec_fmt = FMT_R;
        7'b1110011:             dec_fmt = (funct3 == 3'b000) ? FMT_I : FMT_Z;
        7'b0011011:             dec_fmt = IS64 ? FMT_I : FMT_ILL;
        7'b0111011:             dec_fmt = IS64 ? FMT_R : FMT_ILL;
        default:                dec_fmt = FMT_ILL;
      endcase
    end
  end

  // Assemble the immediate; signed casts replicate inst[31] up to XLEN-1.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = XLEN'($signed(in_inst[31:20]));
      FMT_S: dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B: dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                      in_inst[11:8], 1'b0}));
      FMT_J: dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                      in_inst[30:21], 1'b0}));
      FMT_U: dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_Z: dec_imm = XLEN'(in_inst[19:15]);
      default: dec_imm = '0;
    endcase
  end

  // Pack the decoded fields; the target wraps modulo 2^XLEN.
  always_comb begin
    dec.imm    = dec_imm;
    dec.fmt    = dec_fmt;
    dec.target = in_pc + dec_imm;
  end

  assign in_ready = !skid_full;
  assign in_fire  = in_valid && in_ready;
  // Output register may take new data: it is empty or being consumed now.
  assign out_open = !out_valid || out_ready;

  // Output register and skid entry; skid always drains ahead of new input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: both buffer entries are reset, not just their valid flags, so
      // the output fields read as zero straight out of reset.
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_full <= 1'b0;
      skid_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, regardless of statement order.
      if (out_open) begin
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (in_fire) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
    end
  end

  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = (out_q.fmt == FMT_ILL);
  assign out_target  = out_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share the same
// stimulus. Directed vectors, backpressure and mid-stream reset are checked
// against constants; a long randomized run is checked against an arithmetic
// decode model fed by a queue of accepted instructions.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32;
  logic [2:0]  out_fmt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64;
  logic [2:0]  out_fmt64;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_target(out_target32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_target(out_target64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_fmt(input logic [31:0] inst, input bit x64);
    if (inst[1:0] != 2'b11) return 3'd7;
    case (inst[6:0])
      7'h03, 7'h13, 7'h0F, 7'h67: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h33:                      return 3'd0;
      7'h73:                      return (inst[14:12] == 3'd0) ? 3'd1 : 3'd6;
      7'h1B:                      return x64 ? 3'd1 : 3'd7;
      7'h3B:                      return x64 ? 3'd0 : 3'd7;
      default:                    return 3'd7;
    endcase
  endfunction

  // Two's-complement reinterpretation of an n-bit field.
  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    return v[n-1] ? (v - (64'd1 << n)) : v;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input bit x64);
    logic [63:0] i;
    logic [63:0] v;
    i = 64'(inst);
    case (ref_fmt(inst, x64))
      3'd1: v = sext(i >> 20, 12);
      3'd2: v = sext(((i >> 25) << 5) | ((i >> 7) & 64'd31), 12);
      3'd3: v = sext(((i >> 31) << 12) | (((i >> 7) & 64'd1) << 11) |
                     (((i >> 25) & 64'd63) << 5) | (((i >> 8) & 64'd15) << 1), 13);
      3'd4: v = sext(i & 64'hFFFF_F000, 32);
      3'd5: v = sext(((i >> 31) << 20) | (((i >> 12) & 64'd255) << 12) |
                     (((i >> 20) & 64'd1) << 11) | (((i >> 21) & 64'd1023) << 1), 21);
      3'd6: v = (i >> 15) & 64'd31;
      default: v = 64'd0;
    endcase
    if (!x64) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_tgt(input logic [31:0] inst, input logic [63:0] pc,
                                          input bit x64);
    logic [63:0] t;
    t = pc + ref_imm(inst, x64);
    if (!x64) t = t & 64'hFFFF_FFFF;
    return t;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;

  txn_t        q[$];
  bit          stalled_prev = 1'b0;
  logic [31:0] prev_imm32, prev_tgt32;
  logic [2:0]  prev_fmt32;
  logic [63:0] prev_imm64;

  // Sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    txn_t e;
    if (reset) begin
      q.delete();
      stalled_prev = 1'b0;
    end else begin
      chk("mon_valid32", 64'(out_valid32), 64'(q.size() != 0));
      chk("mon_valid64", 64'(out_valid64), 64'(q.size() != 0));
      chk("mon_ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("mon_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (stalled_prev) begin
        chk("hold_imm32", 64'(out_imm32), 64'(prev_imm32));
        chk("hold_fmt32", 64'(out_fmt32), 64'(prev_fmt32));
        chk("hold_tgt32", 64'(out_target32), 64'(prev_tgt32));
        chk("hold_imm64", out_imm64, prev_imm64);
      end
      if (out_valid32 && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("rd_imm32", 64'(out_imm32), ref_imm(e.inst, 1'b0));
        chk("rd_fmt32", 64'(out_fmt32), 64'(ref_fmt(e.inst, 1'b0)));
        chk("rd_ill32", 64'(out_illegal32), 64'(ref_fmt(e.inst, 1'b0) == 3'd7));
        chk("rd_tgt32", 64'(out_target32), ref_tgt(e.inst, e.pc, 1'b0));
        chk("rd_imm64", out_imm64, ref_imm(e.inst, 1'b1));
        chk("rd_fmt64", 64'(out_fmt64), 64'(ref_fmt(e.inst, 1'b1)));
        chk("rd_ill64", 64'(out_illegal64), 64'(ref_fmt(e.inst, 1'b1) == 3'd7));
        chk("rd_tgt64", out_target64, ref_tgt(e.inst, e.pc, 1'b1));
      end
      if (in_valid && in_ready32) q.push_back('{inst: in_inst, pc: in_pc});
      stalled_prev = out_valid32 && !out_ready;
      prev_imm32   = out_imm32;
      prev_fmt32   = out_fmt32;
      prev_tgt32   = out_target32;
      prev_imm64   = out_imm64;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(9) != 0) begin
      case ($urandom_range(12))
        0:  w[6:0] = 7'h03;
        1:  w[6:0] = 7'h13;
        2:  w[6:0] = 7'h0F;
        3:  w[6:0] = 7'h67;
        4:  w[6:0] = 7'h23;
        5:  w[6:0] = 7'h63;
        6:  w[6:0] = 7'h37;
        7:  w[6:0] = 7'h17;
        8:  w[6:0] = 7'h6F;
        9:  w[6:0] = 7'h33;
        10: w[6:0] = 7'h73;
        11: w[6:0] = 7'h1B;
        default: w[6:0] = 7'h3B;
      endcase
    end
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int  sent;
    int  cyc;
    bit  fire;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_inst   = '0;
    in_pc     = '0;
    #1;
    chk("rst_valid", 64'(out_valid32), 64'd0);
    chk("rst_ready", 64'(in_ready32), 64'd1);
    chk("rst_imm", out_imm64, 64'd0);
    chk("rst_tgt", out_target64, 64'd0);
    chk("rst_fmt", 64'(out_fmt32), 64'd0);
    chk("rst_ill", 64'(out_illegal32), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed decode vectors, back-to-back.
    send(32'hFE000EE3, 64'h100);
    chk("beq_imm", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("beq_fmt", 64'(out_fmt32), 64'd3);
    chk("beq_tgt", 64'(out_target32), 64'h0000_00FC);
    send(32'h001000EF, 64'h0);
    chk("jal_imm", 64'(out_imm32), 64'h0000_0800);
    chk("jal_fmt", 64'(out_fmt32), 64'd5);
    chk("jal_tgt", 64'(out_target32), 64'h800);
    send(32'hFFF00093, 64'h40);
    chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(out_fmt32), 64'd1);
    send(32'h800002B7, 64'h0);
    chk("lui_neg_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt64", 64'(out_fmt64), 64'd4);
    send(32'h123452B7, 64'h0);
    chk("lui_pos_imm64", out_imm64, 64'h0000_0000_1234_5000);
    send(32'h0010809B, 64'h0);
    chk("addiw_fmt64", 64'(out_fmt64), 64'd1);
    chk("addiw_imm64", out_imm64, 64'd1);
    chk("addiw_ill64", 64'(out_illegal64), 64'd0);
    chk("addiw_fmt32", 64'(out_fmt32), 64'd7);
    chk("addiw_ill32", 64'(out_illegal32), 64'd1);
    chk("addiw_imm32", 64'(out_imm32), 64'd0);
    send(32'h300FD073, 64'h0);
    chk("csrrwi_fmt", 64'(out_fmt32), 64'd6);
    chk("csrrwi_imm", 64'(out_imm32), 64'h1F);
    send(32'h00000073, 64'h0);
    chk("ecall_fmt", 64'(out_fmt32), 64'd1);
    chk("ecall_imm", 64'(out_imm32), 64'd0);
    send(32'h00000000, 64'h0);
    chk("zero_fmt", 64'(out_fmt32), 64'd7);
    chk("zero_ill", 64'(out_illegal32), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("idle_valid", 64'(out_valid32), 64'd0);

    // Backpressure: A and B fill both entries, C is held off.
    out_ready = 1'b0;
    send(32'h00100093, 64'h0);
    chk("bp_ready_a", 64'(in_ready32), 64'd1);
    chk("bp_imm_a", 64'(out_imm32), 64'd1);
    send(32'h00200093, 64'h0);
    chk("bp_ready_full", 64'(in_ready32), 64'd0);
    in_inst = 32'h00300093;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_ready", 64'(in_ready32), 64'd0);
      chk("bp_hold_valid", 64'(out_valid32), 64'd1);
      chk("bp_hold_imm", 64'(out_imm32), 64'd1);
    end
    out_ready = 1'b1;
    chk("bp_out_a", 64'(out_imm32), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_out_b", 64'(out_imm32), 64'd2);
    chk("bp_ready_back", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_out_c", 64'(out_imm32), 64'd3);
    chk("bp_valid_c", 64'(out_valid32), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("bp_empty", 64'(out_valid32), 64'd0);

    // Reset between clock edges with both entries occupied.
    out_ready = 1'b0;
    send(32'h00A00093, 64'h0);
    send(32'h00B00093, 64'h0);
    in_valid = 1'b0;
    chk("mr_full", 64'(in_ready32), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid32), 64'd0);
    chk("mr_ready", 64'(in_ready32), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(32'h00D00093, 64'h0);
    chk("mr_d_valid", 64'(out_valid32), 64'd1);
    chk("mr_d_imm", 64'(out_imm32), 64'hD);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("mr_after_d", 64'(out_valid32), 64'd0);

    // Randomized valid/ready traffic; the monitor checks every transfer.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 80000) begin
      @(negedge clk);
      fire = in_valid && in_ready32;
      @(posedge clk);
      #1;
      cyc++;
      if (fire) sent++;
      if (!in_valid || fire) begin
        in_valid = (sent < 10000) && ($urandom_range(3) != 0);
        in_inst  = rand_inst();
        in_pc    = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(9) < 7);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", 64'(sent), 64'd10000);
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1 chk("rand_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
